// File: rtl/core_seq_ctrl_pkg.sv
// core_seq_ctrl_pkg: shared state encodings, bus widths and default reset PC for the NPC sequencer
package core_seq_ctrl_pkg;
  localparam int INST_ADDR_BUS = 32;
  localparam int INST_DATA_BUS = 32;
  localparam logic [INST_ADDR_BUS-1:0] RESET_PC_DEF = 32'h8000_0000;
  typedef enum logic [2:0] {
    CTRL_ST_FETCH  = 3'd0,
    CTRL_ST_DECODE = 3'd1,
    CTRL_ST_EXEC   = 3'd2,
    CTRL_ST_MEM    = 3'd3,
    CTRL_ST_WB     = 3'd4,
    CTRL_ST_HALT   = 3'd5,
    CTRL_ST_TRAP   = 3'd6
  } ctrl_st_e;
endpackage

// File: rtl/core_seq_perf_cnt.sv
// core_seq_perf_cnt: 64-bit cycle and retired-instruction counters for the sequencer
module core_seq_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        retire,
  output logic [63:0] cycle_cnt,
  output logic [63:0] instret
);
  always_ff @(posedge clk) begin
    if (!rst) begin
      cycle_cnt <= '0;
      instret   <= '0;
    end else begin
      if (run) cycle_cnt <= cycle_cnt + 64'd1;
      if (retire) instret <= instret + 64'd1;
    end
  end
endmodule

// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer owning PC and IR.
// Define CORE_SEQ_PERF_CNT_EN to add cycle_cnt_o/instret_o performance counters.
module core_seq_ctrl
  import core_seq_ctrl_pkg::*;
#(
  parameter logic [INST_ADDR_BUS-1:0] RESET_PC    = RESET_PC_DEF,
  parameter int                       MEM_TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     ifetch_req_o,
  output logic [INST_ADDR_BUS-1:0] ifetch_addr_o,
  input  logic                     ifetch_valid_i,
  input  logic [INST_DATA_BUS-1:0] inst_i,
  output logic [INST_DATA_BUS-1:0] ir_o,
  output logic [INST_ADDR_BUS-1:0] pc_o,
  input  logic                     rmem_ena_i,
  input  logic                     wmem_ena_i,
  input  logic                     wena_i,
  input  logic                     ebreak_i,
  input  logic                     unknown_i,
  input  logic                     jump_i,
  input  logic [INST_ADDR_BUS-1:0] jump_target_i,
  output logic                     dmem_req_o,
  output logic                     dmem_we_o,
  input  logic                     dmem_ack_i,
  output logic                     rf_we_o,
  output logic                     retire_o,
  output logic                     halted_o,
  output logic                     trap_o
`ifdef CORE_SEQ_PERF_CNT_EN
  ,
  output logic [63:0]              cycle_cnt_o,
  output logic [63:0]              instret_o
`endif
);
  ctrl_st_e state, nxt;
  logic [INST_ADDR_BUS-1:0] pc;
  logic [INST_DATA_BUS-1:0] ir;
  logic [7:0] cnt;
  logic tmo_hit;
  assign tmo_hit = cnt == 8'(MEM_TIMEOUT - 1);
  always_comb begin
    nxt = state;
    case (state)
      CTRL_ST_FETCH:  nxt = ifetch_valid_i ? CTRL_ST_DECODE : CTRL_ST_FETCH;
      CTRL_ST_DECODE: nxt = unknown_i ? CTRL_ST_TRAP : ebreak_i ? CTRL_ST_HALT : CTRL_ST_EXEC;
      CTRL_ST_EXEC:   nxt = (jump_i && |jump_target_i[1:0]) ? CTRL_ST_TRAP :
                            (rmem_ena_i || wmem_ena_i) ? CTRL_ST_MEM : CTRL_ST_WB;
      // an ack arriving in the last allowed cycle still completes the access
      CTRL_ST_MEM:    nxt = dmem_ack_i ? CTRL_ST_WB : tmo_hit ? CTRL_ST_TRAP : CTRL_ST_MEM;
      CTRL_ST_WB:     nxt = CTRL_ST_FETCH;
      default:        nxt = state;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= CTRL_ST_FETCH;
      pc    <= RESET_PC;
      ir    <= '0;
      cnt   <= '0;
    end else begin
      state <= nxt;
      if (state == CTRL_ST_FETCH && ifetch_valid_i) ir <= inst_i;
      if (state == CTRL_ST_EXEC) cnt <= '0;
      else if (state == CTRL_ST_MEM) cnt <= cnt + 8'd1;
      if (state == CTRL_ST_WB) pc <= jump_i ? jump_target_i : pc + 32'd4;
    end
  end
  // fetch is masked while reset is held so every output idles during reset
  assign ifetch_req_o  = rst && state == CTRL_ST_FETCH;
  assign ifetch_addr_o = pc;
  assign pc_o          = pc;
  assign ir_o          = ir;
  assign dmem_req_o    = state == CTRL_ST_MEM;
  assign dmem_we_o     = state == CTRL_ST_MEM && wmem_ena_i;
  assign rf_we_o       = state == CTRL_ST_WB && wena_i;
  assign retire_o      = state == CTRL_ST_WB;
  assign halted_o      = state == CTRL_ST_HALT;
  assign trap_o        = state == CTRL_ST_TRAP;
`ifdef CORE_SEQ_PERF_CNT_EN
  core_seq_perf_cnt u_perf (
    .clk      (clk),
    .rst      (rst),
    .run      (!(halted_o || trap_o)),
    .retire   (retire_o),
    .cycle_cnt(cycle_cnt_o),
    .instret  (instret_o)
  );
`endif
endmodule

// File: tb/tb_core_seq_ctrl.sv
// tb_core_seq_ctrl: directed and random instruction streams checked against a per-instruction timing model
module tb_core_seq_ctrl;
  localparam logic [31:0] RPC = 32'h8000_0000;
  localparam logic [6:0] F = 7'b1000000, Z = 7'b0000000, H = 7'b0000010, T = 7'b0000001;
  logic clk = 0;
  logic rst = 0;
  always #5 clk = ~clk;
  logic ifetch_valid = 0, rmem_ena = 0, wmem_ena = 0, wena = 0, ebreak = 0, unknown = 0, jump = 0, dmem_ack = 0;
  logic [31:0] inst = '0, jump_target = '0;
  logic ifetch_req [2], dmem_req [2], dmem_we [2], rf_we [2], retire [2], halted [2], trap [2];
  logic [31:0] ifetch_addr [2], ir [2], pc [2];
`ifdef CORE_SEQ_PERF_CNT_EN
  logic [63:0] cyc_cnt [2], instret [2];
`endif
  int sel = 0, tests = 0, fails = 0;
  logic [31:0] mpc = RPC;

  core_seq_ctrl #(.RESET_PC(RPC), .MEM_TIMEOUT(255)) u0 (
    .clk(clk), .rst(rst), .ifetch_req_o(ifetch_req[0]), .ifetch_addr_o(ifetch_addr[0]),
    .ifetch_valid_i(ifetch_valid), .inst_i(inst), .ir_o(ir[0]), .pc_o(pc[0]),
    .rmem_ena_i(rmem_ena), .wmem_ena_i(wmem_ena), .wena_i(wena), .ebreak_i(ebreak),
    .unknown_i(unknown), .jump_i(jump), .jump_target_i(jump_target),
    .dmem_req_o(dmem_req[0]), .dmem_we_o(dmem_we[0]), .dmem_ack_i(dmem_ack),
    .rf_we_o(rf_we[0]), .retire_o(retire[0]), .halted_o(halted[0]), .trap_o(trap[0])
`ifdef CORE_SEQ_PERF_CNT_EN
    , .cycle_cnt_o(cyc_cnt[0]), .instret_o(instret[0])
`endif
  );
  core_seq_ctrl #(.RESET_PC(RPC), .MEM_TIMEOUT(4)) u1 (
    .clk(clk), .rst(rst), .ifetch_req_o(ifetch_req[1]), .ifetch_addr_o(ifetch_addr[1]),
    .ifetch_valid_i(ifetch_valid), .inst_i(inst), .ir_o(ir[1]), .pc_o(pc[1]),
    .rmem_ena_i(rmem_ena), .wmem_ena_i(wmem_ena), .wena_i(wena), .ebreak_i(ebreak),
    .unknown_i(unknown), .jump_i(jump), .jump_target_i(jump_target),
    .dmem_req_o(dmem_req[1]), .dmem_we_o(dmem_we[1]), .dmem_ack_i(dmem_ack),
    .rf_we_o(rf_we[1]), .retire_o(retire[1]), .halted_o(halted[1]), .trap_o(trap[1])
`ifdef CORE_SEQ_PERF_CNT_EN
    , .cycle_cnt_o(cyc_cnt[1]), .instret_o(instret[1])
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // e = {ifetch_req, dmem_req, dmem_we, rf_we, retire, halted, trap}
  task automatic cyc(input string tag, input logic [6:0] e);
    #1;
    chk({tag, ":ctl"}, {25'd0, ifetch_req[sel], dmem_req[sel], dmem_we[sel], rf_we[sel],
                        retire[sel], halted[sel], trap[sel]}, {25'd0, e});
    chk({tag, ":pc"}, pc[sel], mpc);
    chk({tag, ":ifa"}, ifetch_addr[sel], mpc);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst = 0; ifetch_valid = 0; dmem_ack = 0;
    @(posedge clk);
    #1;
    chk({tag, ":ctl"}, {25'd0, ifetch_req[sel], dmem_req[sel], dmem_we[sel], rf_we[sel],
                        retire[sel], halted[sel], trap[sel]}, 32'd0);
    chk({tag, ":pc"}, pc[sel], RPC);
    chk({tag, ":ifa"}, ifetch_addr[sel], RPC);
    chk({tag, ":ir"}, ir[sel], 32'd0);
    rst = 1;
    mpc = RPC;
  endtask

  // terminal state: nothing requested, pc frozen, stray handshakes ignored
  task automatic terminal(input string tag, input logic [6:0] e);
    ifetch_valid = 1; dmem_ack = 1; inst = $urandom;
    repeat (3) cyc({tag, ":term"}, e);
    ifetch_valid = 0; dmem_ack = 0;
  endtask

  // one instruction: fw fetch wait cycles, ack on MEM cycle aw (0 = never)
  task automatic do_inst(input string tag, input int fw, input logic [31:0] w,
                         input logic ld, input logic st, input logic we, input logic eb,
                         input logic unk, input logic jmp, input logic [31:0] tgt, input int aw);
    int tmo;
    tmo = sel ? 4 : 255;
    rmem_ena = ld; wmem_ena = st; wena = we; ebreak = eb; unknown = unk;
    jump = jmp; jump_target = tgt; dmem_ack = 0;
    ifetch_valid = 0;
    repeat (fw) cyc({tag, ":fw"}, F);
    ifetch_valid = 1; inst = w;
    cyc({tag, ":fetch"}, F);
    ifetch_valid = 0; inst = $urandom;
    chk({tag, ":ir"}, ir[sel], w);
    cyc({tag, ":dec"}, Z);
    if (unk) begin terminal(tag, T); return; end
    if (eb) begin terminal(tag, H); return; end
    cyc({tag, ":exec"}, Z);
    if (jmp && tgt[1:0] != 2'b00) begin terminal(tag, T); return; end
    if (ld || st) begin
      for (int k = 1; k <= tmo; k++) begin
        dmem_ack = (k == aw);
        cyc({tag, ":mem"}, {2'b01, st, 4'b0000});
        if (k == aw) break;
      end
      dmem_ack = 0;
      if (aw == 0 || aw > tmo) begin terminal(tag, T); return; end
    end
    cyc({tag, ":wb"}, {3'b000, we, 1'b1, 2'b00});
    mpc = jmp ? tgt : mpc + 32'd4;
  endtask

  initial begin
    int c, a;
    logic [31:0] t;
    do_reset("rst0");
    do_inst("addi", 0, 32'h00100093, 0, 0, 1, 0, 0, 0, 0, 0);
    chk("addi:pc4", pc[0], 32'h8000_0004);
    do_inst("st5", 1, 32'h00112023, 0, 1, 0, 0, 0, 0, 0, 5);
    do_inst("ld1", 2, 32'h00012083, 1, 0, 1, 0, 0, 0, 0, 1);
    do_inst("jal", 0, 32'h1000006f, 0, 0, 1, 0, 0, 1, 32'h8000_0100, 0);
    do_inst("wrapj", 1, 32'h0000006f, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0);
    do_inst("wrap", 0, 32'h00000013, 0, 0, 1, 0, 0, 0, 0, 0);
    chk("wrap:pc0", pc[0], 32'd0);
    for (int n = 0; n < 24; n++) begin
      c = $urandom_range(0, 3);
      t = $urandom;
      t[1:0] = 2'b00;
      do_inst("rnd", $urandom_range(0, 3), $urandom, c == 1, c == 2, 1'($urandom), 0, 0,
              c == 3, t, $urandom_range(1, 6));
    end
    do_inst("jmis", 0, 32'h1020006f, 0, 0, 1, 0, 0, 1, 32'h8000_0102, 0);
    do_reset("rst1");
    do_inst("unk", 1, 32'hFFFF_FFFF, 0, 0, 1, 1, 1, 0, 0, 0);
    do_reset("rst2");
    do_inst("pre", 0, 32'h00100093, 0, 0, 1, 0, 0, 0, 0, 0);
    do_inst("ebrk", 0, 32'h00100073, 0, 0, 0, 1, 0, 0, 0, 0);
    do_reset("rst3");
    rmem_ena = 1; wmem_ena = 0; wena = 1; ebreak = 0; unknown = 0; jump = 0;
    ifetch_valid = 1; inst = 32'h00012083;
    cyc("rm:fetch", F);
    ifetch_valid = 0;
    cyc("rm:dec", Z);
    cyc("rm:exec", Z);
    cyc("rm:mem1", 7'b0100000);
    cyc("rm:mem2", 7'b0100000);
    do_reset("rm:rst");
    dmem_ack = 1;
    cyc("rm:late", F);
    do_inst("rm:after", 0, 32'h00100093, 0, 0, 1, 0, 0, 0, 0, 0);
    sel = 1;
    do_reset("t4:rst");
    do_inst("t4:noack", 0, 32'h00012083, 1, 0, 1, 0, 0, 0, 0, 0);
    do_reset("t4:rst2");
    do_inst("t4:ack4", 1, 32'h00012083, 1, 0, 1, 0, 0, 0, 0, 4);
    for (int n = 0; n < 10; n++) begin
      a = $urandom_range(1, 5);
      do_inst("t4:rnd", $urandom_range(0, 2), $urandom, 1'($urandom), 1'b1, 1'($urandom),
              0, 0, 0, 0, a);
      if (a == 5) do_reset("t4:rrst");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/core_seq_ctrl.md
Name: core_seq_ctrl

Overview:
- Multi-cycle sequencer for the NPC core.
- Owns the PC and the instruction register.
- Drives the instruction-fetch and data-memory request handshakes.
- Steps each instruction through FETCH, DECODE, EXEC, optional MEM, and WB, using the decoder's classification flags.
- Gates register-file writes to the WB cycle. Halts on ebreak and traps on unknown instructions or a memory timeout.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- MEM_TIMEOUT, 255, maximum cycles spent waiting in MEM for dmem_ack_i before trapping; range 1..255.

Ports:
- clk  input  1  core clock.
- rst  input  1  reset; one clock; reset is synchronous and active-low.
- ifetch_req_o  output  1  instruction fetch request.
- ifetch_addr_o  output  32  fetch address (equals pc_o).
- ifetch_valid_i  input  1  instruction word valid on inst_i.
- inst_i  input  32  fetched instruction word.
- ir_o  output  32  latched instruction to the decoder.
- pc_o  output  32  PC of the current instruction.
- rmem_ena_i  input  1  decoder: load.
- wmem_ena_i  input  1  decoder: store.
- wena_i  input  1  decoder: writes rd.
- ebreak_i  input  1  decoder: ebreak.
- unknown_i  input  1  decoder: illegal encoding.
- jump_i  input  1  transfer unit: branch/jump taken.
- jump_target_i  input  32  transfer unit: target PC.
- dmem_req_o  output  1  data-memory request.
- dmem_we_o  output  1  data-memory write (store).
- dmem_ack_i  input  1  data-memory completion.
- rf_we_o  output  1  gated register-file write enable.
- retire_o  output  1  one-cycle pulse per retired instruction.
- halted_o  output  1  sticky; ebreak executed.
- trap_o  output  1  sticky; illegal instruction, misaligned target, or memory timeout.

Behaviour:
- **Reset** (rst==0 at posedge):
  - State goes to FETCH and pc to RESET_PC. ir is cleared to 0 and the timeout counter to 0.
  - All outputs are 0 except pc_o/ifetch_addr_o, which equal RESET_PC.
  - Reset mid-operation aborts any outstanding request immediately. Late ifetch_valid_i/dmem_ack_i are ignored unless in the matching state.
- **States**: FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP.
- **FETCH**:
  - ifetch_req_o=1.
  - On ifetch_valid_i: ir<=inst_i, go to DECODE. Zero-wait valid in the first FETCH cycle is accepted.
- **DECODE** (1 cycle; decoder and regfile read on ir):
  - unknown_i -> TRAP.
  - else ebreak_i -> HALT.
  - else -> EXEC.
- **EXEC** (1 cycle):
  - rmem_ena_i|wmem_ena_i -> MEM, counter cleared.
  - else -> WB.
  - If jump_i and jump_target_i[1:0]!=0 -> TRAP; this check takes priority.
- **MEM**:
  - dmem_req_o=1 held every cycle; dmem_we_o=wmem_ena_i.
  - On dmem_ack_i -> WB.
  - Otherwise the counter increments. When the counter reaches MEM_TIMEOUT without an ack -> TRAP.
  - An ack in the same cycle the counter reaches MEM_TIMEOUT wins and goes to WB.
- **WB** (1 cycle):
  - rf_we_o=wena_i; retire_o=1.
  - pc <= jump_i ? jump_target_i : pc+4. The addition is 32-bit modulo, so 32'hFFFF_FFFC+4 wraps to 0.
  - -> FETCH.
- **HALT**: terminal; halted_o=1; no requests issued. The ebreak does not retire.
- **TRAP**: terminal; trap_o=1; no requests issued; pc_o frozen at the faulting instruction.
- **Latency**:
  - Non-memory instruction: fetch wait + 3 cycles.
  - Memory instruction: fetch wait + ack wait + 4 cycles.
- rf_we_o, dmem_req_o, and ifetch_req_o are never high outside WB, MEM, and FETCH respectively.

Optional Feature:
- Macro CORE_SEQ_PERF_CNT_EN.
- Defined:
  - Adds output cycle_cnt_o[63:0], counting every post-reset cycle except HALT/TRAP.
  - Adds output instret_o[63:0], incrementing on retire_o.
  - Both counters reset to 0.
- Undefined: both ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared defines header:
  - State encodings CTRL_ST_FETCH..CTRL_ST_TRAP (3-bit).
  - RESET_PC default.
  - Width macros reuse INST_ADDR_BUS and INST_DATA_BUS.
- One sub-module core_seq_perf_cnt holds the two 64-bit counters, instantiated only under CORE_SEQ_PERF_CNT_EN.

Test Plan:
- **Reset then addi**: release rst, valid the next cycle with inst 32'h00100093 and wena_i=1. Expect:
  - ifetch_addr_o=32'h8000_0000.
  - rf_we_o high exactly once, 3 cycles after acceptance, with retire_o.
  - Next pc_o=32'h8000_0004.
- **Store with 5-cycle ack delay** (wmem_ena_i=1): dmem_req_o and dmem_we_o held for 5 cycles; rf_we_o stays 0; retire_o fires on WB; pc advances by 4.
- **Taken jump**, jump_i=1, jump_target_i=32'h8000_0100: next ifetch_addr_o=32'h8000_0100. The same stimulus with target 32'h8000_0102 -> trap_o=1 after EXEC and no retire.
- **unknown_i=1 in DECODE** -> trap_o sticky and no further ifetch_req_o. **ebreak_i=1** -> halted_o sticky and retire count unchanged.
- **Load with no ack**, MEM_TIMEOUT=4: trap_o asserted after 4 MEM cycles. A separate run with ack on exactly cycle 4 -> WB, no trap.
- **Reset mid-MEM**: drive rst=0 during MEM. Next cycle dmem_req_o=0, state is FETCH, pc_o=RESET_PC, and a late dmem_ack_i is ignored.
